// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one external 4-bit logic unit (Sel: 0=A&B, 1=A|B, 2=A^B, 3=~A)
//   among NREQ requesters. It uses round-robin arbitration and a valid/ready
//   handshake per requester. Operands are captured into lu_a/lu_b/lu_sel at
//   grant. The result is registered and returned with the requester id.
//   Sequence: IDLE (grant) -> EXEC (unit evaluates) -> RESP (hold until taken).
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   per-requester handshake; req_ready is the one-hot grant
//   req_a/b/sel       packed operands, requester i at [4i+3:4i] / [2i+1:2i]
//   lu_a/b/sel, lu_e  drive to / result from the shared logic unit
//   rsp_valid/ready   result handshake; rsp_id, rsp_data carry the result
//   busy              high whenever not IDLE
//   op_count          completed-op counter, present only with LU_OPCNT_EN defined
module logic_unit_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0] req_sel,
  output logic [3:0]        lu_a,
  output logic [3:0]        lu_b,
  output logic [1:0]        lu_sel,
  input  logic [3:0]        lu_e,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_data,
  output logic              busy
`ifdef LU_OPCNT_EN
  , output logic [15:0]     op_count
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic           any;
  logic           grant;
  int             idx;

  // The search walks the offsets from highest to lowest. The last match
  // written is therefore the first valid requester at or after rr_ptr.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        win = IDW'(idx);
        any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // The grant depends only on state and req_valid. This gives rsp_ready no
  // path to req_ready.
  always_comb begin
    state_n   = state;
    grant     = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: if (any) begin
        grant   = 1'b1;
        state_n = EXEC;
      end
      EXEC:    state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (grant && !rst) req_ready[win] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      lu_a      <= '0;
      lu_b      <= '0;
      lu_sel    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (grant) begin
        lu_a   <= req_a[4*int'(win) +: 4];
        lu_b   <= req_b[4*int'(win) +: 4];
        lu_sel <= req_sel[2*int'(win) +: 2];
        rsp_id <= win;
        rr_ptr <= (int'(win) == NREQ-1) ? '0 : win + IDW'(1);
      end
      if (state == EXEC) begin
        rsp_data  <= lu_e;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef LU_OPCNT_EN
  always_ff @(posedge clk) begin
    if (rst)                          op_count <= '0;
    else if (rsp_valid && rsp_ready)  op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [2*NREQ-1:0] req_sel;
  logic [3:0]        lu_a, lu_b, lu_e, rsp_data;
  logic [1:0]        lu_sel;
  logic              rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]    rsp_id;
`ifdef LU_OPCNT_EN
  logic [15:0]       op_count;
`endif

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] lu_f(logic [3:0] a, logic [3:0] b, logic [1:0] s);
    case (s)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // The shared unit sits outside the DUT.
  assign lu_e = lu_f(lu_a, lu_b, lu_sel);

  logic_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_e(lu_e),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
`ifdef LU_OPCNT_EN
    , .op_count(op_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    req_a[4*i +: 4]   = a;
    req_b[4*i +: 4]   = b;
    req_sel[2*i +: 2] = s;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    #1 chk("ready_in_rst", req_ready, 0);
    cyc();
    cyc();
    rst = 1'b0; req_valid = '0;
    #1;
  endtask

  // Runs one op from an idle arbiter with only requester r valid.
  task automatic run_op(input int r, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] s, input logic [3:0] exp, input string nm);
    set_req(r, a, b, s);
    req_valid = NREQ'(1 << r);
    #1 chk({nm, "_grant"}, req_ready, 1 << r);
    cyc();
    req_valid = '0;
    cyc();
    chk({nm, "_valid"}, rsp_valid, 1);
    chk({nm, "_data"}, rsp_data, exp);
    chk({nm, "_id"}, rsp_id, r);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] s;
    logic [3:0] e;
  } vec_t;

  vec_t vecs[4];

  // Transaction-level reference: phase 0 idle, 1 executing, 2 response pending.
  int         m_ph, m_rr, m_win, m_id;
  logic [3:0] m_data, m_la, m_lb;
  logic [1:0] m_ls;
  int         m_cnt;
  bit         m_any;

  initial begin
    vecs[0] = '{4'b1100, 4'b1010, 2'd0, 4'b1000};
    vecs[1] = '{4'b1100, 4'b1010, 2'd1, 4'b1110};
    vecs[2] = '{4'b1100, 4'b1010, 2'd2, 4'b0110};
    vecs[3] = '{4'b0101, 4'b0000, 2'd3, 4'b1010};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
    do_reset();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lu", {lu_a, lu_b, lu_sel}, 0);
    chk("rst_rsp", {rsp_id, rsp_data}, 0);

    // Single-op latency: the grant is in cycle T and the response appears at T+2.
    set_req(0, 4'b1100, 4'b1010, 2'd0);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1 chk("t1_grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    chk("t1_exec_ready", req_ready, 0);
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_valid", rsp_valid, 0);
    chk("t1_lu_a", lu_a, 4'b1100);
    cyc();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_data", rsp_data, 4'b1000);
    chk("t1_id", rsp_id, 0);
    cyc();
    rsp_ready = 1'b0;
    chk("t1_done_valid", rsp_valid, 0);
    chk("t1_done_busy", busy, 0);
    chk("t1_lu_hold", {lu_a, lu_b, lu_sel}, {4'b1100, 4'b1010, 2'b00});

    for (int i = 0; i < 4; i++)
      run_op(i, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, $sformatf("vec%0d", i));

    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run_op((a + b) % NREQ, 4'(a), 4'(b), 2'(s), lu_f(4'(a), 4'(b), 2'(s)), "exh");

    // All requesters held valid: the grants must rotate 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i), 4'hF, 2'd0);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("rr_grant%0d", k), req_ready, 1 << (k % NREQ));
      cyc();
      cyc();
      chk($sformatf("rr_id%0d", k), rsp_id, k % NREQ);
      chk($sformatf("rr_data%0d", k), rsp_data, k % NREQ);
      cyc();
    end
    req_valid = '0; rsp_ready = 1'b0;

    // Response backpressure: the result must hold stable for 5 stalled cycles.
    do_reset();
    set_req(2, 4'b0011, 4'b0101, 2'd2);
    req_valid = 4'b0100;
    #1 chk("bp_grant", req_ready, 4'b0100);
    cyc();
    cyc();
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 4'b0110);
      chk("bp_id", rsp_id, 2);
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_valid6", rsp_valid, 1);
    cyc();
    rsp_ready = 1'b0; req_valid = '0;
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_valid", rsp_valid, 0);

    // Reset during EXEC discards the op and returns rr_ptr to 0.
    do_reset();
    set_req(2, 4'b1111, 4'b1111, 2'd0);
    req_valid = 4'b0100;
    #1 chk("mr_grant", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    chk("mr_exec", busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_valid", rsp_valid, 0);
    chk("mr_busy", busy, 0);
    cyc();
    chk("mr_valid2", rsp_valid, 0);
    set_req(1, 4'b1001, 4'b0011, 2'd1);
    req_valid = 4'b1010;
    #1 chk("mr_grant1", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    cyc();
    chk("mr_id", rsp_id, 1);
    chk("mr_data", rsp_data, 4'b1011);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

`ifdef LU_OPCNT_EN
    do_reset();
    chk("cnt_rst", op_count, 0);
    for (int i = 0; i < 3; i++) run_op(i, 4'hA, 4'h5, 2'd1, 4'hF, "cnt");
    chk("cnt_3", op_count, 3);
`endif

    // Randomized traffic checked against the transaction-level model.
    do_reset();
    m_ph = 0; m_rr = 0; m_id = 0; m_data = '0; m_la = '0; m_lb = '0; m_ls = '0; m_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = NREQ'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      req_sel   = 8'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      m_any = 0; m_win = 0;
      for (int k = 0; k < NREQ; k++)
        if (!m_any && req_valid[(m_rr + k) % NREQ]) begin
          m_any = 1;
          m_win = (m_rr + k) % NREQ;
        end
      chk("rnd_ready", req_ready, (!rst && m_ph == 0 && m_any) ? (1 << m_win) : 0);
      chk("rnd_busy", busy, m_ph != 0);
      chk("rnd_valid", rsp_valid, m_ph == 2);
      if (m_ph == 2) begin
        chk("rnd_id", rsp_id, m_id);
        chk("rnd_data", rsp_data, m_data);
      end
      chk("rnd_lu", {lu_a, lu_b, lu_sel}, {m_la, m_lb, m_ls});
`ifdef LU_OPCNT_EN
      chk("rnd_cnt", op_count, m_cnt);
`endif
      if (rst) begin
        m_ph = 0; m_rr = 0; m_la = '0; m_lb = '0; m_ls = '0; m_cnt = 0;
      end else if (m_ph == 0) begin
        if (m_any) begin
          m_la   = req_a[4*m_win +: 4];
          m_lb   = req_b[4*m_win +: 4];
          m_ls   = req_sel[2*m_win +: 2];
          m_id   = m_win;
          m_data = lu_f(m_la, m_lb, m_ls);
          m_rr   = (m_win + 1) % NREQ;
          m_ph   = 1;
        end
      end else if (m_ph == 1) begin
        m_ph = 2;
      end else if (rsp_ready) begin
        m_ph  = 0;
        m_cnt = (m_cnt + 1) % 65536;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
